// File: rtl/serial_pkg.sv
// State encoding and line constants shared by the bit serializer and the
// downstream 101 sequence detector.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 1;

  // Level driven on the serial line when no word is in flight
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period counter: pulses tick in the last Clk cycle of every DIV-cycle
// bit period while enabled. Restarts on clear so a new word begins a full period.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST_COUNT) ? '0 : r_count + CW'(1);
    end
  end

  // With one cycle per bit every cycle closes a period
  assign tick = (DIV == 1) ? 1'b1 : (r_count == LAST_COUNT);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the 101 detector: accepts a word on a
// valid/ready handshake and shifts it out one bit per period, back-to-back capable.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV       = DEFAULT_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             b,
  output logic             b_valid,
  output logic             last
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitCount;
  logic             w_shifting;
  logic             w_tick;
  logic             w_endOfWord;
  logic             w_accept;
  logic             w_head;

  assign w_shifting  = (r_state == SHIFT);
  assign w_endOfWord = w_shifting && (r_bitCount == LAST_BIT) && w_tick;
  assign w_accept    = load && ready;
  assign w_head      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tickGen (
    .Clk   (Clk),
    .Rst   (Rst),
    .clear (w_accept),
    .enable(w_shifting),
    .tick  (w_tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The end-of-word cycle doubles as an accept slot so words can chain without a gap
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (load) w_nextState = SHIFT;
      SHIFT:   if (w_endOfWord && !load) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_shift    <= '0;
      r_bitCount <= '0;
    end else if (w_accept) begin
      r_shift    <= din;
      r_bitCount <= '0;
    end else if (w_shifting && w_tick) begin
      r_shift    <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
      r_bitCount <= (r_bitCount == LAST_BIT) ? '0 : r_bitCount + BW'(1);
    end
  end

  assign ready   = !w_shifting || w_endOfWord;
  assign b       = w_shifting ? w_head : IDLE_LEVEL;
  assign b_valid = w_shifting;
  assign last    = w_endOfWord;

endmodule
